// File: rtl/risc_fetch_buffer.sv
// Fetch stage with a request/response instruction-memory port and a DEPTH-entry in-order buffer.
// Slots are allocated at request time, filled by in-order responses, and handed to decode via valid/ready.
module risc_fetch_buffer #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc,
  output logic [XLEN-1:0] dec_pc_plus4
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] slot_pc    [DEPTH];
  logic [XLEN-1:0] slot_pc4   [DEPTH];
  logic [XLEN-1:0] slot_instr [DEPTH];
  logic [DEPTH-1:0] slot_filled;

  logic [PW-1:0] alloc_ptr;
  logic [PW-1:0] fill_ptr;
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] drop_cnt;

  logic [AW-1:0] alloc_idx;
  logic [AW-1:0] fill_idx;
  logic [AW-1:0] head_idx;
  logic [PW-1:0] occupancy;
  logic          full;
  logic          accept;
  logic          rsp_drop;
  logic          rsp_fill;
  logic          deq;
  logic [PW-1:0] pending;
  logic [PW-1:0] redirect_drop;
  logic [XLEN-1:0] redirect_target;

  assign alloc_idx = alloc_ptr[AW-1:0];
  assign fill_idx  = fill_ptr[AW-1:0];
  assign head_idx  = head_ptr[AW-1:0];

  assign occupancy = alloc_ptr - head_ptr;
  assign full      = (occupancy == PW'(DEPTH));

  assign imem_req_valid = !full && !redirect_valid && !rst;
  assign imem_req_addr  = pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
  assign rsp_fill = imem_rsp_valid && (drop_cnt == '0) && (fill_ptr != alloc_ptr);

  assign dec_valid    = slot_filled[head_idx] && (head_ptr != alloc_ptr) && !redirect_valid;
  assign dec_instr    = slot_instr[head_idx];
  assign dec_pc       = slot_pc[head_idx];
  assign dec_pc_plus4 = slot_pc4[head_idx];
  assign deq          = dec_valid && dec_ready;

  // On redirect every live in-flight fetch becomes stale; a response landing this cycle retires one of them.
  assign pending         = drop_cnt + (alloc_ptr - fill_ptr);
  assign redirect_drop   = pending - PW'(imem_rsp_valid && (pending != '0));
  assign redirect_target = redirect_pc & ~XLEN'(3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      alloc_ptr   <= '0;
      fill_ptr    <= '0;
      head_ptr    <= '0;
      drop_cnt    <= '0;
      slot_filled <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_pc[i]    <= '0;
        slot_pc4[i]   <= '0;
        slot_instr[i] <= '0;
      end
    end else if (redirect_valid) begin
      pc_q        <= redirect_target;
      alloc_ptr   <= '0;
      fill_ptr    <= '0;
      head_ptr    <= '0;
      drop_cnt    <= redirect_drop;
      slot_filled <= '0;
    end else begin
      if (accept) begin
        slot_pc[alloc_idx]     <= pc_q;
        slot_pc4[alloc_idx]    <= pc_q + XLEN'(4);
        slot_filled[alloc_idx] <= 1'b0;
        alloc_ptr              <= alloc_ptr + PW'(1);
        pc_q                   <= pc_q + XLEN'(4);
      end
      if (rsp_drop) begin
        drop_cnt <= drop_cnt - PW'(1);
      end
      if (rsp_fill) begin
        slot_instr[fill_idx]  <= imem_rsp_data;
        slot_filled[fill_idx] <= 1'b1;
        fill_ptr              <= fill_ptr + PW'(1);
      end
      // The head slot is always already filled, so it never collides with the slot being filled.
      if (deq) begin
        slot_filled[head_idx] <= 1'b0;
        head_ptr              <= head_ptr + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_risc_fetch_buffer.sv
// Self-checking bench for risc_fetch_buffer: in-order memory model plus a queue-based
// reference of the fetch stream (in-flight fetches and fetched-but-undecoded PCs).
module tb_risc_fetch_buffer;

  localparam int DEPTH = 4;
  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [31:0] dec_pc_plus4;

  risc_fetch_buffer #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr),
    .dec_pc(dec_pc), .dec_pc_plus4(dec_pc_plus4)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; bit live; } fetch_t;
  typedef struct { int due; logic [31:0] data; } rsp_t;

  fetch_t      inflight[$];
  logic [31:0] ready_q[$];
  rsp_t        mem_q[$];
  logic [31:0] ref_pc;
  int          mem_last_due;
  int          cyc;
  int          lat;

  bit          redir, rdy, drdy;
  logic [31:0] redir_pc;
  bit          obs_rv, obs_dv;
  logic [31:0] obs_addr, obs_pc, obs_instr, obs_pc4;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {pc[15:0], pc[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; dec_ready = 1'b0;
    inflight.delete(); ready_q.delete(); mem_q.delete();
    ref_pc = RPC; cyc = 0; mem_last_due = -1;
    #1;
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_dec_valid", dec_valid, 1'b0);
    chk("rst_req_addr", imem_req_addr, RPC);
    chk("rst_dec_instr", dec_instr, 32'h0);
    chk("rst_dec_pc", dec_pc, 32'h0);
    chk("rst_dec_pc_plus4", dec_pc_plus4, 32'h0);
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare against the reference, then advance the reference.
  task automatic step();
    int live;
    bit exp_req, exp_dv, acc, deq, rsp;
    fetch_t f;
    rsp_t r;
    redirect_valid = redir; redirect_pc = redir_pc;
    imem_req_ready = rdy;   dec_ready = drdy;
    rsp = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_q[0].data : $urandom;
    #1;
    obs_rv = imem_req_valid; obs_dv = dec_valid; obs_addr = imem_req_addr;
    obs_pc = dec_pc; obs_instr = dec_instr; obs_pc4 = dec_pc_plus4;
    live = 0;
    foreach (inflight[i]) if (inflight[i].live) live++;
    exp_req = ((live + ready_q.size()) < DEPTH) && !redir;
    exp_dv  = (ready_q.size() > 0) && !redir;
    chk("req_valid", imem_req_valid, exp_req);
    if (exp_req) chk("req_addr", imem_req_addr, ref_pc);
    chk("dec_valid", dec_valid, exp_dv);
    if (exp_dv) begin
      chk("dec_pc", dec_pc, ready_q[0]);
      chk("dec_instr", dec_instr, instr_of(ready_q[0]));
      chk("dec_pc_plus4", dec_pc_plus4, ready_q[0] + 32'd4);
    end
    acc = exp_req && rdy;
    deq = exp_dv && drdy;
    if (rsp) void'(mem_q.pop_front());
    if (redir) begin
      foreach (inflight[i]) inflight[i].live = 1'b0;
      ready_q.delete();
      if (rsp && inflight.size() > 0) void'(inflight.pop_front());
      ref_pc = redir_pc & ~32'd3;
    end else begin
      if (deq) void'(ready_q.pop_front());
      if (rsp && inflight.size() > 0) begin
        f = inflight.pop_front();
        if (f.live) ready_q.push_back(f.pc);
      end
      if (acc) begin
        f.pc = ref_pc; f.live = 1'b1;
        inflight.push_back(f);
        r.due = (cyc + lat > mem_last_due + 1) ? cyc + lat : mem_last_due + 1;
        r.data = instr_of(ref_pc);
        mem_last_due = r.due;
        mem_q.push_back(r);
        ref_pc = ref_pc + 32'd4;
      end
    end
    @(posedge clk); #2;
    cyc++;
  endtask

  task automatic wait_dv(output bit got);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (obs_dv) begin got = 1'b1; break; end
    end
  endtask

  initial begin
    int first_acc, first_dv, cnt;
    bit got;
    logic [31:0] held, addr0;

    redir = 0; redir_pc = '0; rdy = 0; drdy = 0; lat = 1;
    do_reset();

    // Reset and stream
    rdy = 1; drdy = 1; lat = 1;
    first_acc = -1; first_dv = -1; cnt = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (obs_rv && first_acc < 0) first_acc = cyc - 1;
      if (obs_dv && first_dv < 0) first_dv = cyc - 1;
      if (i >= 4 && obs_dv) cnt++;
    end
    chk("first_dv_latency", first_dv - first_acc, 2);
    chk("stream_throughput", cnt, 10);

    // Backpressure until full
    redir = 1; redir_pc = 32'h300; drdy = 0; step(); redir = 0;
    cnt = 0; held = '0; got = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (obs_rv) cnt++;
      if (obs_dv && !got) begin got = 1; held = obs_instr; end
    end
    chk("full_accepts", cnt, 4);
    chk("full_req_valid", obs_rv, 1'b0);
    chk("held_instr", obs_instr, held);
    drdy = 1;
    for (int i = 0; i < 8; i++) step();

    // Redirect with three in-flight fetches, no response that cycle
    lat = 4;
    redir = 1; redir_pc = 32'h400; step(); redir = 0;
    for (int i = 0; i < 3; i++) step();
    redir = 1; redir_pc = 32'h203; step(); redir = 0;
    step();
    chk("redirect_addr", obs_addr, 32'h200);
    wait_dv(got);
    chk("redirect_dv_timeout", got, 1'b1);
    chk("redirect_first_pc", obs_pc, 32'h200);
    for (int i = 0; i < 6; i++) step();

    // Redirect with a response in the same cycle
    lat = 3;
    redir = 1; redir_pc = 32'h500; step(); redir = 0;
    for (int i = 0; i < 4; i++) step();
    redir = 1; redir_pc = 32'h600; step(); redir = 0;
    wait_dv(got);
    chk("simul_dv_timeout", got, 1'b1);
    chk("simul_first_pc", obs_pc, 32'h600);
    for (int i = 0; i < 8; i++) step();

    // Memory stall
    lat = 1;
    redir = 1; redir_pc = 32'h700; rdy = 0; step(); redir = 0;
    cnt = 0; addr0 = 32'h700;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_addr", obs_addr, addr0);
      if (obs_dv) cnt++;
    end
    chk("stall_no_dv", cnt, 0);
    rdy = 1;
    for (int i = 0; i < 6; i++) step();

    // Address wrap
    redir = 1; redir_pc = 32'hFFFF_FFFC; step(); redir = 0;
    step(); chk("wrap_addr0", obs_addr, 32'hFFFF_FFFC);
    step(); chk("wrap_addr1", obs_addr, 32'h0000_0000);
    step(); chk("wrap_pc_plus4", obs_pc4, 32'h0000_0000);
    cnt = 1;
    for (int i = 0; i < 24; i++) begin
      step();
      if (obs_dv) cnt++;
    end
    chk("wrap_delivered", cnt >= 20, 1'b1);

    // Randomized traffic
    lat = 2;
    for (int i = 0; i < 400; i++) begin
      rdy  = ($urandom_range(0, 3) != 0);
      drdy = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 39) == 0);
      redir_pc = $urandom;
      step();
    end
    redir = 0;

    // Reset in the middle of traffic
    rdy = 1; drdy = 1;
    for (int i = 0; i < 5; i++) step();
    do_reset();
    step(); chk("post_reset_addr", obs_addr, RPC);
    for (int i = 0; i < 6; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
